// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU instruction sequencer: register reads, external ALU, write-back
// Optional ALU_SEQ_FLAGS_EN adds alu_flags/flags ports capturing ALU status per instruction.

package pkg_reg;
    localparam int REG_ADDRW = 4;
    localparam int REG_WIDTH = 16;
endpackage

package pkg_alu;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_PASS
    } op_t;
    typedef enum logic {ALU_REG, ALU_IMM} sel_t;
endpackage

module alu_seq
    import pkg_reg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 ready,
    input  pkg_alu::op_t         op,
    input  pkg_alu::sel_t        a_sel,
    input  logic [REG_ADDRW-1:0] s_reg,
    input  logic [REG_ADDRW-1:0] b_reg,
    input  logic [REG_ADDRW-1:0] a_reg,
    input  logic [REG_WIDTH-1:0] a_imm,
    output logic [REG_ADDRW-1:0] rd_addr,
    input  logic [REG_WIDTH-1:0] rd_data,
    output logic                 wr_en,
    output logic [REG_ADDRW-1:0] wr_addr,
    output logic [REG_WIDTH-1:0] wr_data,
    output pkg_alu::op_t         alu_op,
    output logic [REG_WIDTH-1:0] alu_a,
    output logic [REG_WIDTH-1:0] alu_b,
    input  logic [REG_WIDTH-1:0] alu_s,
    output logic                 done
`ifdef ALU_SEQ_FLAGS_EN
    ,
    input  logic [3:0]           alu_flags,
    output logic [3:0]           flags
`endif
);

    typedef enum logic [2:0] {IDLE, RD_B, RD_A, EXEC, WB} state_t;

    state_t                 state_q, state_d;
    pkg_alu::op_t           op_q;
    pkg_alu::sel_t          sel_q;
    logic [REG_ADDRW-1:0]   s_q, b_q, a_q;
    logic [REG_WIDTH-1:0]   imm_q;
    logic [REG_WIDTH-1:0]   opb_q;
    logic [REG_WIDTH-1:0]   res_q;
    pkg_alu::op_t           hold_op_q;
    logic [REG_WIDTH-1:0]   hold_a_q, hold_b_q;
    logic [REG_ADDRW-1:0]   exec_src;
    logic [REG_WIDTH-1:0]   exec_val, b_val;

    // Register 0 reads as zero no matter what the register file returns.
    assign b_val    = (b_q == '0) ? '0 : rd_data;
    assign exec_src = (sel_q == pkg_alu::ALU_REG) ? a_q : b_q;
    assign exec_val = (exec_src == '0) ? '0 : rd_data;

    assign wr_addr = s_q;
    assign wr_data = res_q;

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        done    = 1'b0;
        alu_op  = hold_op_q;
        alu_a   = hold_a_q;
        alu_b   = hold_b_q;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) state_d = RD_B;
            end
            RD_B: begin
                rd_addr = b_q;
                state_d = (sel_q == pkg_alu::ALU_REG) ? RD_A : EXEC;
            end
            RD_A: begin
                rd_addr = a_q;
                state_d = EXEC;
            end
            EXEC: begin
                alu_op = op_q;
                if (sel_q == pkg_alu::ALU_REG) begin
                    alu_a = exec_val;
                    alu_b = opb_q;
                end else begin
                    alu_a = imm_q;
                    alu_b = exec_val;
                end
                state_d = WB;
            end
            WB: begin
                // A reset landing in the write-back cycle kills the write outright.
                done    = !rst;
                wr_en   = !rst && (s_q != '0);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= pkg_alu::OP_ADD;
            sel_q     <= pkg_alu::ALU_REG;
            s_q       <= '0;
            b_q       <= '0;
            a_q       <= '0;
            imm_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
            hold_op_q <= pkg_alu::OP_ADD;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                op_q  <= op;
                sel_q <= a_sel;
                s_q   <= s_reg;
                b_q   <= b_reg;
                a_q   <= a_reg;
                imm_q <= a_imm;
            end
            if (state_q == RD_A) opb_q <= b_val;
            if (state_q == EXEC) begin
                hold_op_q <= alu_op;
                hold_a_q  <= alu_a;
                hold_b_q  <= alu_b;
                res_q     <= alu_s;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    // Captured at the end of EXEC, so the new value first appears in WB.
    always_ff @(posedge clk) begin
        if (rst) flags <= '0;
        else if (state_q == EXEC) flags <= alu_flags;
    end
`endif

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  instruction valid
- ready  out  1  block can accept an instruction
- op  in  pkg_alu::op_t  ALU operation
- a_sel  in  pkg_alu::sel_t  ALU_REG or ALU_IMM
- s_reg, b_reg, a_reg  in  REG_ADDRW each  destination and source register addresses
- a_imm  in  REG_WIDTH  immediate operand
- rd_addr  out  REG_ADDRW  register-file read address; read data valid 1 cycle later
- rd_data  in  REG_WIDTH  register-file read data
- wr_en  out  1  register-file write strobe
- wr_addr  out  REG_ADDRW  write address
- wr_data  out  REG_WIDTH  write data
- alu_op  out  pkg_alu::op_t  to combinational ALU
- alu_a, alu_b  out  REG_WIDTH  ALU operands
- alu_s  in  REG_WIDTH  ALU result, combinational from alu_op/alu_a/alu_b
- done  out  1  one-cycle pulse in the write-back cycle
REQ-003 REG_ADDRW and REG_WIDTH SHALL come from pkg_reg; the block SHALL have no parameters.

Function
REQ-004 States SHALL be IDLE, RD_B, RD_A, EXEC, WB.
REQ-005 ready SHALL be 1 only in IDLE; start with ready=1 latches op, a_sel, s_reg, b_reg, a_reg, a_imm and moves to RD_B.
REQ-006 start while ready=0 SHALL be ignored, and latched fields SHALL not change.
REQ-007 RD_B: rd_addr=b_reg; next state is RD_A if a_sel==ALU_REG, else EXEC.
REQ-008 RD_A: latch operand B from rd_data, drive rd_addr=a_reg, go to EXEC.
REQ-009 EXEC: alu_op=op; ALU_REG: alu_b=latched B, alu_a=rd_data; ALU_IMM: alu_b=rd_data, alu_a=a_imm; latch alu_s; go to WB.
REQ-010 Any operand read from register address 0 SHALL be forced to 0, regardless of rd_data.
REQ-011 WB: wr_addr=s_reg, wr_data=latched result, done=1, wr_en=1 unless s_reg==0 (no write, done still 1); go to IDLE.
REQ-012 Latency from accept cycle T: done at T+4 (ALU_REG), T+3 (ALU_IMM); next accept no earlier than the cycle after done.
REQ-013 Outside EXEC, alu_a, alu_b and alu_op SHALL be held at their last values; outside WB, wr_en=0 and done=0.
REQ-014 Operand and result widths SHALL be exactly REG_WIDTH; no extension, truncation or carry handling occurs in this block.

Reset
REQ-015 rst=1 SHALL force IDLE, ready=1, wr_en=0, done=0, rd_addr=0, wr_addr=0, wr_data=0, alu_a=0, alu_b=0, and clear all latched fields, in the next cycle.
REQ-016 rst asserted in any state, including WB, SHALL suppress that write and any later write for the aborted instruction.
REQ-017 rst SHALL take priority over a simultaneous start.

Configuration
REQ-018 Macro ALU_SEQ_FLAGS_EN defined: add input alu_flags[3:0] (ZF, CF, OF, SF from the ALU) and output flags[3:0]. alu_flags SHALL be latched in EXEC and presented on flags from WB onward until the next WB. flags SHALL reset to 0.
REQ-019 Macro ALU_SEQ_FLAGS_EN undefined: neither port exists, and behaviour is otherwise identical.

Verification
REQ-020 Reg mode: RF %1=5, %2=7; start op=ADD, a_sel=REG, b=1, a=2, s=3 at T -> alu_b=5, alu_a=7 at T+3; wr_en, wr_addr=3, wr_data=12, done at T+4.
REQ-021 Imm mode: %1=10; op=SUB, a_sel=IMM, a_imm=3, b=1, s=4 at T -> write 7 to %4 with done at T+3; rd_addr never equals a_reg.
REQ-022 Zero register: b=0 with rd_data stuck 0xFFFF..., s=0 -> alu_b=0; done=1 with wr_en=0.
REQ-023 Busy: second start held high from T+1 to T+4 -> ignored; accepted at T+5 with new fields; first write is unaffected.
REQ-024 Reset mid-op: rst in WB cycle -> wr_en=0, done=0; IDLE and ready=1 next cycle.
REQ-025 With ALU_SEQ_FLAGS_EN: ADD 0xFFFF...+1 with ALU carry/zero asserted -> flags ZF=1, CF=1 at WB and held through the following IDLE.
